sync_fifo: RTL

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 21 ++
 rtl/sync_fifo_ram.sv | 52 +++++
 rtl/sync_fifo.sv | 113 +++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared constants and helpers for the synchronous FIFO.
//               Holds the default geometry/threshold values and a function
//               that derives the entry count from the pointer width.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int DEF_FIFO_PTR   = 4;
  localparam int DEF_FIFO_WIDTH = 8;
  localparam int DEF_AEMPTY_LVL = 2;

  // Number of entries addressed by a pointer of 'ptr' address bits.
  function automatic int depth_of(input int ptr);
    return 1 << ptr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_ram
// Description : Single-clock storage array, one write port and one
//               registered read port. The array itself has no reset; only
//               the read-data register is cleared by rst_n.
// Ports       : clk, rst_n        - clock, async active-low reset
//               we, waddr, wdata  - write port
//               re, raddr, rdata  - read port (rdata registered)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_PTR   = DEF_FIFO_PTR,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [FIFO_PTR-1:0]   waddr,
  input  logic [FIFO_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [FIFO_PTR-1:0]   raddr,
  output logic [FIFO_WIDTH-1:0] rdata
);

  localparam int DEPTH = depth_of(FIFO_PTR);

  logic [FIFO_WIDTH-1:0] r_mem [DEPTH];
  logic [FIFO_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read sees the pre-edge array contents, so a same-address write on a
  // full FIFO pass-through cycle does not disturb the word being popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Synchronous FIFO with registered status flags, occupancy
//               count and sticky overflow/underflow error flags.
// Ports       : clk, rst_n                - clock, async active-low reset
//               wren, wrdata              - write request and data
//               rden, rddata, rdvalid     - read request, data, valid pulse
//               full, empty, almost_full, almost_empty, count - status
//               overflow, underflow, clr_err - sticky errors and their clear
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_PTR   = DEF_FIFO_PTR,
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int AFULL_LVL  = depth_of(FIFO_PTR) - 2,
  parameter int AEMPTY_LVL = DEF_AEMPTY_LVL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wren,
  input  logic [FIFO_WIDTH-1:0] wrdata,
  input  logic                  rden,
  output logic [FIFO_WIDTH-1:0] rddata,
  output logic                  rdvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [FIFO_PTR:0]     count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [FIFO_PTR:0] c_afull_lvl  = (FIFO_PTR+1)'(AFULL_LVL);
  localparam logic [FIFO_PTR:0] c_aempty_lvl = (FIFO_PTR+1)'(AEMPTY_LVL);
  localparam logic [FIFO_PTR:0] c_zero_ext   = '0;

  logic [FIFO_PTR:0] r_wptr, r_rptr, r_count;
  logic [FIFO_PTR:0] w_wptr_nxt, w_rptr_nxt, w_count_nxt;
  logic              r_full, r_empty, r_afull, r_aempty;
  logic              r_rdvalid, r_ovf, r_unf;
  logic              w_wr_acc, w_rd_acc, w_ovf_evt, w_unf_evt;

  // A full FIFO still takes a write when a read frees the slot this edge.
  assign w_wr_acc  = wren & (~r_full | rden);
  assign w_rd_acc  = rden & ~r_empty;
  assign w_ovf_evt = wren & r_full & ~rden;
  assign w_unf_evt = rden & r_empty;

  assign w_wptr_nxt  = r_wptr + {c_zero_ext[FIFO_PTR:1], w_wr_acc};
  assign w_rptr_nxt  = r_rptr + {c_zero_ext[FIFO_PTR:1], w_rd_acc};
  assign w_count_nxt = r_count + {c_zero_ext[FIFO_PTR:1], w_wr_acc}
                               - {c_zero_ext[FIFO_PTR:1], w_rd_acc};

  // Flags are computed from next-state values so they describe the FIFO
  // after this edge while staying free of any input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_afull   <= 1'b0;
      r_aempty  <= 1'b1;
      r_rdvalid <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_wptr    <= w_wptr_nxt;
      r_rptr    <= w_rptr_nxt;
      r_count   <= w_count_nxt;
      r_empty   <= (w_wptr_nxt == w_rptr_nxt);
      r_full    <= (w_wptr_nxt[FIFO_PTR-1:0] == w_rptr_nxt[FIFO_PTR-1:0]) &&
                   (w_wptr_nxt[FIFO_PTR] != w_rptr_nxt[FIFO_PTR]);
      r_afull   <= (w_count_nxt >= c_afull_lvl);
      r_aempty  <= (w_count_nxt <= c_aempty_lvl);
      r_rdvalid <= w_rd_acc;
      // A new error in the clearing cycle wins over the clear.
      r_ovf     <= (r_ovf & ~clr_err) | w_ovf_evt;
      r_unf     <= (r_unf & ~clr_err) | w_unf_evt;
    end
  end

  sync_fifo_ram #(
    .FIFO_PTR   (FIFO_PTR),
    .FIFO_WIDTH (FIFO_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_wr_acc),
    .waddr (r_wptr[FIFO_PTR-1:0]),
    .wdata (wrdata),
    .re    (w_rd_acc),
    .raddr (r_rptr[FIFO_PTR-1:0]),
    .rdata (rddata)
  );

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign rdvalid      = r_rdvalid;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule
`default_nettype wire
